regfile_mp: RTL and testbench

//  Parametrised multi-port register file; next generation of the datapath register file.

---
 rtl/regfile_mp_pkg.sv | 22 ++
 rtl/regfile_clear_fsm.sv | 62 ++++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file:
// state encodings, default sizes and a clog2 helper.
package regfile_mp_pkg;

    typedef enum logic {
        RF_ST_CLEAR = 1'b0,
        RF_ST_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer for regfile_mp: owns the CLEAR/READY state and
// the sweep pointer; zeroes entries 1..DEPTH-1, one per cycle.
// Ports:
//   elk      clock
//   nrst     synchronous active-high reset (restarts the sweep)
//   clr_req  soft-clear request, honoured only in READY
//   ready    1 = array valid
//   clr_we   sweep write strobe
//   clr_addr entry being zeroed this cycle
module regfile_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = rf_clog2(DEPTH)
) (
    input  logic              elk,
    input  logic              nrst,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge elk) begin
        if (nrst) begin
            state_q <= RF_ST_CLEAR;
            ptr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Entry 0 is never swept: it reads as zero regardless.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        unique case (state_q)
            RF_ST_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST) state_d = RF_ST_READY;
            end
            RF_ST_READY: begin
                if (clr_req) begin
                    state_d = RF_ST_CLEAR;
                    ptr_d   = ADDR_W'(1);
                end
            end
        endcase
    end

    assign ready    = (state_q == RF_ST_READY);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async read ports, two write ports
// (port 1 wins on conflict), entry 0 hardwired to zero, built-in clear.
// Ports:
//   elk, nrst (sync active-high), clr_req, ready
//   wr_en[2], wr_addr[2*ADDR_W], wr_data[2*DATA_W]
//   rd_addr[NUM_RD*ADDR_W], rd_data[NUM_RD*DATA_W] (combinational)
// Option: REGFILE_BYPASS_EN enables same-cycle write-through on reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = rf_clog2(DEPTH)
) (
    input  logic                     elk,
    input  logic                     nrst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic [1:0]        we;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .elk      (elk),
        .nrst     (nrst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wa0 = wr_addr[0 +: ADDR_W];
    assign wa1 = wr_addr[ADDR_W +: ADDR_W];
    assign wd0 = wr_data[0 +: DATA_W];
    assign wd1 = wr_data[DATA_W +: DATA_W];
    assign we  = {wr_en[1] && (wa1 != '0),
                  wr_en[0] && (wa0 != '0)};

    // Port 1 is assigned last so it overrides port 0 on a conflict.
    always_ff @(posedge elk) begin
        if (!nrst) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (ready) begin
                if (we[0]) mem[wa0] <= wd0;
                if (we[1]) mem[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = '0;
            if (ready && (ra != '0)) begin
                rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (we[1] && (wa1 == ra))      rv = wd1;
                else if (we[0] && (wa0 == ra)) rv = wd0;
`endif
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp
// (default sizes: DATA_W=32, DEPTH=32, NUM_RD=2).
module tb_regfile_mp;

    logic        elk = 1'b0;
    logic        nrst;
    logic        clr_req;
    logic        ready;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    regfile_mp dut (
        .elk     (elk),
        .nrst    (nrst),
        .clr_req (clr_req),
        .ready   (ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 elk = ~elk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge elk);
        #1;
    endtask

    task automatic wr(input logic [1:0] en,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rd_addr = {b, a};
        #1;
    endtask

    // Counts edges until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        nrst    = 1'b1;
        clr_req = 1'b0;
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd_addr = '0;
        step();
        step();
        rd(5'd1, 5'd31);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rd_a", rd_data[31:0], 32'h0);
        chk("rst_rd_b", rd_data[63:32], 32'h0);

        nrst = 1'b0;
        wait_ready(cnt);
        chk("rst_len", cnt, 32'd31);
        rd(5'd7, 5'd31);
        chk("init_rd_a", rd_data[31:0], 32'h0);
        chk("init_rd_b", rd_data[63:32], 32'h0);

        // Basic dual write
        wr(2'b11, 5'd1, 32'h11111110, 5'd3, 32'h33333330);
        rd(5'd1, 5'd3);
`ifdef REGFILE_BYPASS_EN
        chk("byp_basic_a", rd_data[31:0], 32'h11111110);
`else
        chk("pre_basic_a", rd_data[31:0], 32'h0);
`endif
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd1, 5'd3);
        chk("basic_r1", rd_data[31:0], 32'h11111110);
        chk("basic_r3", rd_data[63:32], 32'h33333330);
        rd(5'd3, 5'd3);
        chk("same_a", rd_data[31:0], 32'h33333330);
        chk("same_b", rd_data[63:32], 32'h33333330);

        // Conflict: port 1 wins
        wr(2'b11, 5'd2, 32'h22222220, 5'd2, 32'h44444440);
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd2, 5'd1);
        chk("conflict_r2", rd_data[31:0], 32'h44444440);
        chk("conflict_r1", rd_data[63:32], 32'h11111110);

        // Zero register
        wr(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd0, 5'd0);
        chk("r0_a", rd_data[31:0], 32'h0);
        chk("r0_b", rd_data[63:32], 32'h0);

        // Soft clear
        wr(2'b01, 5'd4, 32'h44444440, 5'd0, 32'h0);
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd4, 5'd3);
        chk("r4_set", rd_data[31:0], 32'h44444440);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        rd(5'd4, 5'd3);
        chk("clr_ready", {31'b0, ready}, 32'd0);
        chk("clr_rd_a", rd_data[31:0], 32'h0);
        chk("clr_rd_b", rd_data[63:32], 32'h0);
        step();
        step();
        step();
        // Entry 1 is already swept; this write must be dropped
        wr(2'b11, 5'd1, 32'hAAAAAAAA, 5'd2, 32'hBBBBBBBB);
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        wait_ready(cnt);
        chk("clr_len", cnt + 4, 32'd31);
        rd(5'd4, 5'd3);
        chk("clr_r4", rd_data[31:0], 32'h0);
        chk("clr_r3", rd_data[63:32], 32'h0);
        rd(5'd1, 5'd2);
        chk("clr_lost_r1", rd_data[31:0], 32'h0);
        chk("clr_lost_r2", rd_data[63:32], 32'h0);

        // Reset mid-sweep
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        wait_ready(cnt);
        chk("mid_rst_len", cnt, 32'd31);

        // Bypass / write-through
        wr(2'b01, 5'd5, 32'h55555550, 5'd0, 32'h0);
        rd(5'd5, 5'd6);
`ifdef REGFILE_BYPASS_EN
        chk("byp_r5", rd_data[31:0], 32'h55555550);
`else
        chk("nobyp_r5", rd_data[31:0], 32'h0);
`endif
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd5, 5'd6);
        chk("r5_after", rd_data[31:0], 32'h55555550);

        wr(2'b11, 5'd5, 32'h0000AAAA, 5'd5, 32'h0000BBBB);
        rd(5'd5, 5'd5);
`ifdef REGFILE_BYPASS_EN
        chk("byp_prio", rd_data[31:0], 32'h0000BBBB);
`else
        chk("nobyp_prio", rd_data[31:0], 32'h55555550);
`endif
        step();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd5, 5'd5);
        chk("prio_after", rd_data[63:32], 32'h0000BBBB);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
